// File: rtl/bool_pkg.sv
// Shared types and helpers for the exhaustive boolean-function sweeper.
package bool_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int MAX_N = 8;

    function automatic logic [MAX_N-1:0] bin2gray(input logic [MAX_N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic int num_vec(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/bool_gray_cnt.sv
// N-bit binary sweep counter; exposes the next count in binary or Gray order
// so the parent can register the vector in the same cycle the counter steps.
module bool_gray_cnt
    import bool_pkg::*;
#(
    parameter int N    = 4,
    parameter int GRAY = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [N-1:0] code_nxt_o,
    output logic         last_o
);

    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == {N{1'b1}});

    // Zero-extending before the Gray transform leaves the low N bits correct.
    if (GRAY != 0) begin : g_gray
        assign code_nxt_o = N'(bin2gray(MAX_N'(cnt_d)));
    end else begin : g_bin
        assign code_nxt_o = cnt_d;
    end

endmodule

// File: rtl/bool_sweep.sv
// Latches an N-input truth table and streams every (vector, F) pair over a
// valid/ready handshake, counting minterms with F=1.
module bool_sweep
    import bool_pkg::*;
#(
    parameter int N    = 4,
    parameter int GRAY = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [(1<<N)-1:0]       tt_in,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [N-1:0]            vec_out,
    output logic                    f_out,
    output logic [N:0]              ones_count,
    output logic                    busy,
    output logic                    done
);

    localparam int NUM_VEC = num_vec(N);

    state_e               state_q, state_d;
    logic [NUM_VEC-1:0]   tt_q, tt_d;
    logic                 valid_q, valid_d;
    logic [N-1:0]         vec_q, vec_d;
    logic                 f_q, f_d;
    logic [N:0]           ones_q, ones_d;
    logic                 done_q, done_d;

    logic                 cnt_clr;
    logic                 cnt_en;
    logic [N-1:0]         code_nxt;
    logic                 cnt_last;
    logic                 xfer;

    bool_gray_cnt #(
        .N    (N),
        .GRAY (GRAY)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (cnt_clr),
        .en_i       (cnt_en),
        .code_nxt_o (code_nxt),
        .last_o     (cnt_last)
    );

    assign xfer = valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        tt_d    = tt_q;
        valid_d = valid_q;
        vec_d   = vec_q;
        f_d     = f_q;
        ones_d  = ones_q;
        done_d  = done_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        // Abort outranks start and any pending transfer.
        if (abort) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            done_d  = 1'b0;
            vec_d   = '0;
            f_d     = 1'b0;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        tt_d    = tt_in;
                        cnt_clr = 1'b1;
                        ones_d  = '0;
                        done_d  = 1'b0;
                        valid_d = 1'b1;
                        vec_d   = code_nxt;
                        f_d     = tt_in[code_nxt];
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        ones_d = ones_q + {{N{1'b0}}, f_q};
                        if (cnt_last) begin
                            state_d = ST_DONE;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            cnt_en = 1'b1;
                            vec_d  = code_nxt;
                            f_d    = tt_q[code_nxt];
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tt_q    <= '0;
            valid_q <= 1'b0;
            vec_q   <= '0;
            f_q     <= 1'b0;
            ones_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tt_q    <= tt_d;
            valid_q <= valid_d;
            vec_q   <= vec_d;
            f_q     <= f_d;
            ones_q  <= ones_d;
            done_q  <= done_d;
        end
    end

    assign out_valid  = valid_q;
    assign vec_out    = vec_q;
    assign f_out      = f_q;
    assign ones_count = ones_q;
    assign busy       = (state_q == ST_RUN);
    assign done       = done_q;

endmodule

// File: tb/tb_bool_sweep.sv
// Directed bench: a binary-order and a Gray-order instance share all inputs.
module tb_bool_sweep;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] tt_in = 16'h0000;
    logic        out_ready = 1'b0;

    logic        valid_b, f_b, busy_b, done_b;
    logic [3:0]  vec_b;
    logic [4:0]  ones_b;
    logic        valid_g, f_g, busy_g, done_g;
    logic [3:0]  vec_g;
    logic [4:0]  ones_g;

    int total = 0;
    int bad   = 0;

    int gseq [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    bool_sweep #(.N(4), .GRAY(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .tt_in(tt_in),
        .out_ready(out_ready), .out_valid(valid_b), .vec_out(vec_b), .f_out(f_b),
        .ones_count(ones_b), .busy(busy_b), .done(done_b)
    );

    bool_sweep #(.N(4), .GRAY(1)) dut_g (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .tt_in(tt_in),
        .out_ready(out_ready), .out_valid(valid_g), .vec_out(vec_g), .f_out(f_g),
        .ones_count(ones_g), .busy(busy_g), .done(done_g)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [15:0] tt);
        tt_in = tt;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [15:0] tt_cur;
        int          exp_k;
        int          cyc;

        // Reset state
        #1;
        check("rst_valid", valid_b, 0);
        check("rst_busy",  busy_b,  0);
        check("rst_done",  done_b,  0);
        check("rst_ones",  ones_b,  0);
        check("rst_vec",   vec_b,   0);
        check("rst_f",     f_b,     0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Binary and Gray sweep of 16'hA5F0 with continuous ready
        out_ready = 1'b1;
        tt_cur = 16'hA5F0;
        kick(tt_cur);
        for (int k = 0; k < 16; k++) begin
            check("t1_valid", valid_b, 1);
            check("t1_busy",  busy_b,  1);
            check("t1_vec",   vec_b,   k);
            check("t1_f",     f_b,     tt_cur[k]);
            check("t1g_vec",  vec_g,   gseq[k]);
            check("t1g_f",    f_g,     tt_cur[gseq[k]]);
            tick();
        end
        check("t1_done",   done_b,  1);
        check("t1_valid0", valid_b, 0);
        check("t1_busy0",  busy_b,  0);
        check("t1_ones",   ones_b,  8);
        check("t1g_ones",  ones_g,  8);
        check("t1_lastvec", vec_b,  15);

        // All-ones table from DONE, Gray order, no overflow
        tt_cur = 16'hFFFF;
        kick(tt_cur);
        check("t2_done0", done_b, 0);
        for (int k = 0; k < 16; k++) begin
            check("t2g_vec", vec_g, gseq[k]);
            check("t2g_f",   f_g,   1);
            tick();
        end
        check("t2g_done", done_g, 1);
        check("t2g_ones", ones_g, 16);
        check("t2_ones",  ones_b, 16);

        // Backpressure: ready 1,0,0 repeating
        tt_cur = 16'h1234;
        kick(tt_cur);
        exp_k = 0;
        cyc = 0;
        while (exp_k < 16 && cyc < 100) begin
            out_ready = (cyc % 3 == 0);
            check("t3_valid", valid_b, 1);
            check("t3_vec",   vec_b,   exp_k);
            check("t3_f",     f_b,     tt_cur[exp_k]);
            if (out_ready) exp_k++;
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        check("t3_all_sent", exp_k,  16);
        check("t3_done",     done_b, 1);
        check("t3_ones",     ones_b, 5);
        check("t3g_ones",    ones_g, 5);

        // Abort when vec_out reaches 6
        tt_cur = 16'hA5F0;
        kick(tt_cur);
        cyc = 0;
        while (vec_b != 4'd6 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("t4_reached6", vec_b, 6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_valid", valid_b, 0);
        check("t4_done",  done_b,  0);
        check("t4_busy",  busy_b,  0);
        check("t4_ones",  ones_b,  2);
        check("t4g_ones", ones_g,  2);
        tick();
        check("t4_idle_valid", valid_b, 0);

        tt_cur = 16'h0001;
        kick(tt_cur);
        for (int k = 0; k < 16; k++) begin
            check("t4r_vec", vec_b, k);
            check("t4r_f",   f_b,   tt_cur[k]);
            tick();
        end
        check("t4r_done", done_b, 1);
        check("t4r_ones", ones_b, 1);
        check("t4rg_ones", ones_g, 1);

        // Start mid-sweep with a new table is ignored
        tt_cur = 16'h00FF;
        kick(tt_cur);
        tt_in = 16'hFFFF;
        for (int k = 0; k < 16; k++) begin
            start = (k == 3);
            check("t5_vec", vec_b, k);
            check("t5_f",   f_b,   tt_cur[k]);
            tick();
        end
        start = 1'b0;
        check("t5_done",  done_b, 1);
        check("t5_ones",  ones_b, 8);
        check("t5g_ones", ones_g, 8);

        // Asynchronous reset mid-sweep
        kick(16'hFFFF);
        tick();
        tick();
        tick();
        check("t6_pre_ones", ones_b, 3);
        rst_n = 1'b0;
        #1;
        check("t6_valid", valid_b, 0);
        check("t6_busy",  busy_b,  0);
        check("t6_done",  done_b,  0);
        check("t6_ones",  ones_b,  0);
        check("t6g_valid", valid_g, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_post_valid", valid_b, 0);
            check("t6_post_busy",  busy_b,  0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bool_sweep.md
Name: bool_sweep

Overview:
- Parametrised sequential successor to the fixed 4-input boolean-expression blocks: holds an N-input boolean function as a latched truth table and sweeps every input combination in order.
- Emits one (input vector, F) pair per valid/ready transfer, counts the minterms where F=1, and signals completion.
- Replaces hand-written stimulus sequences. Serves as a reusable on-chip exhaustive evaluator feeding a logger, display or checker downstream.

Parameters:
- N, 4, number of function inputs (1..8); the truth table has 2^N entries.
- GRAY, 0, 0 = binary sweep order, 1 = Gray-code order (adjacent vectors differ in one bit).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: latch tt_in and begin a sweep (honoured in IDLE and DONE only)
- abort  in  1  pulse: terminate the sweep and return to IDLE
- tt_in  in  2^N  truth table; bit k = F for input vector k (bit N-1 of the vector = A, MSB)
- out_ready  in  1  downstream accepts current pair
- out_valid  out  1  vec_out/f_out hold a valid pair
- vec_out  out  N  current input vector (A..D order for N=4, MSB first)
- f_out  out  1  tt_latched[vec_out]
- ones_count  out  N+1  number of transferred pairs with f_out=1
- busy  out  1  high in RUN
- done  out  1  high in DONE (sticky until start or abort)

Behaviour:
- Reset (async assert, sync release): state=IDLE, idx=0, tt_latched=0, out_valid=0, vec_out=0, f_out=0, ones_count=0, busy=0, done=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN
  - RUN --last transfer--> DONE
  - RUN --abort--> IDLE
  - DONE --start--> RUN
  - DONE --abort--> IDLE
- On accepted start:
  - tt_latched <= tt_in, idx <= 0, ones_count <= 0, done <= 0.
  - First pair is presented the next cycle (latency 1).
  - Start while in RUN is ignored; tt_in is not re-sampled mid-sweep.
- RUN:
  - out_valid=1.
  - vec_out = idx (GRAY=0) or idx ^ (idx>>1) (GRAY=1).
  - f_out = tt_latched[vec_out]. Outputs are registered and stable while out_valid && !out_ready.
- Transfer = out_valid && out_ready. On transfer:
  - ones_count += f_out.
  - If idx == 2^N-1: go to DONE, out_valid <= 0.
  - Otherwise idx++ and the next pair is presented the next cycle. A continuous out_ready gives one pair per cycle, 2^N cycles total.
- Counter widths:
  - idx is N bits and never wraps inside a sweep.
  - ones_count is N+1 bits, so the all-ones table yields 2^N without overflow.
- DONE: out_valid=0, busy=0, done=1. ones_count and the last vec_out are held.
- Abort has priority over start and transfer in the same cycle:
  - IDLE is entered next cycle with out_valid=0, done=0, idx=0.
  - ones_count keeps its partial value until the next start.
- Async reset mid-sweep: all outputs go to reset values immediately. No partial pair is emitted after release.

Decomposition:
- Shared package bool_pkg:
  - state enum (IDLE/RUN/DONE)
  - function bin2gray(N-bit)
  - constant NUM_VEC(N) = 1<<N
- One natural sub-module, bool_gray_cnt: N-bit binary counter with enable/clear and a Gray-coded output. Instantiated once; its Gray output is bypassed when GRAY=0.

Test Plan:
- N=4, GRAY=0, tt_in=16'hA5F0, out_ready=1:
  - start -> vec_out 0..15 on consecutive cycles, f_out = bit k of 16'hA5F0 for each k.
  - done rises the cycle after vec_out=15 is transferred; ones_count=8.
- N=4, GRAY=1, tt_in=16'hFFFF:
  - vec_out sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8 (each step differs by one bit).
  - ones_count=16 (5'b10000, no overflow).
- Backpressure with out_ready toggling 1,0,0,1,...:
  - vec_out and f_out stay frozen while out_ready=0.
  - No vector is skipped or duplicated; ones_count matches the truth table at the end.
- Abort at vec_out=6 -> IDLE next cycle, out_valid=0, done=0, ones_count holds its partial value. A subsequent start with tt_in=16'h0001 sweeps from 0 and ends with ones_count=1.
- Start pulsed mid-sweep with a different tt_in -> ignored; the sweep completes using the originally latched table.
- rst_n asserted low mid-sweep -> out_valid, busy, done and ones_count go to 0 asynchronously. After release, no output appears until the next start.
